// File: rtl/port_rx_buffer_if.sv
// Purpose: packet-word + per-packet keep-flag bus between receive stages.
// Latency: wires only, no storage.
// Backpressure: pkt_almostfull flows from the slave back to the master.
//
// Signals:
//   pkt_wrreq / pkt     : one 134-bit packet word per strobe
//                         [133:132] 01 first, 11 middle, 10 last;
//                         [131:128] invalid bytes in last word; [127:0] data.
//   valid_wrreq / valid : one keep(1)/drop(0) flag per packet.
//   pkt_almostfull      : receiver is close to full.
interface port_rx_buffer_if;
  logic         pkt_wrreq;
  logic [133:0] pkt;
  logic         valid_wrreq;
  logic         valid;
  logic         pkt_almostfull;

  modport master (
    output pkt_wrreq, pkt, valid_wrreq, valid,
    input  pkt_almostfull
  );

  modport slave (
    input  pkt_wrreq, pkt, valid_wrreq, valid,
    output pkt_almostfull
  );
endinterface

// File: rtl/port_rx_buffer.sv
// Purpose: show-ahead synchronous FIFO with occupancy count and overflow flag.
// Latency: a word written at edge t is visible on q from t+1.
// Backpressure: a write into a full FIFO is dropped (ovf=1) unless a pop happens in the same cycle.
//
// Ports: clk/reset, wr/din push side, rd pop side, q head word,
//        empty, usedw occupancy, ovf combinational reject indication.
module port_rx_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         q,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic                     ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             wr_ok;
  logic             rd_ok;

  assign empty = (usedw == '0);
  assign full  = (usedw == FULL_CNT);
  assign rd_ok = rd & ~empty;
  // A pop in the same cycle frees the slot, so a push to a full FIFO is still taken.
  assign wr_ok = wr & (~full | rd_ok);
  assign ovf   = wr & ~wr_ok;
  assign q     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usedw  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   usedw <= usedw + 1'b1;
        2'b01:   usedw <= usedw - 1'b1;
        default: usedw <= usedw;
      endcase
    end
  end
endmodule

// Purpose: per-port receive buffer; drops packets flagged bad, replays good ones word for word.
// Latency: keep flag written at t -> first out_pkt_wrreq at t+3, then 1 word/cycle.
// Backpressure: out almost-full only gates packet starts; in almost-full is a registered occupancy threshold.
//
// Ports: clk, reset (async active-low),
//        in_if  (slave)  : words + flags from the MAC receive adapter, in_pkt_almostfull back,
//        out_if (master) : words + flags to the ingress pipeline, out_pkt_almostfull in,
//        pkt_forward_add / pkt_drop_add / overflow_add : one-cycle statistics pulses.
module port_rx_buffer #(
  parameter int PKT_DEPTH = 256,
  parameter int VLD_DEPTH = 64,
  parameter int AF_MARGIN = 24
) (
  input  logic              clk,
  input  logic              reset,
  port_rx_buffer_if.slave   in_if,
  port_rx_buffer_if.master  out_if,
  output logic              pkt_forward_add,
  output logic              pkt_drop_add,
  output logic              overflow_add
);
  localparam int PAW = $clog2(PKT_DEPTH);
  localparam int VAW = $clog2(VLD_DEPTH);
  localparam logic [PAW:0] PKT_AF_LVL = (PAW+1)'(PKT_DEPTH - AF_MARGIN);
  localparam logic [VAW:0] VLD_AF_LVL = (VAW+1)'(VLD_DEPTH - 4);

  typedef enum logic [1:0] {IDLE, SEND, DISCARD} state_t;
  state_t state;

  logic [133:0] pkt_head;
  logic         pkt_empty;
  logic [PAW:0] pkt_usedw;
  logic         pkt_ovf;
  logic         pkt_rd;
  logic         flag_head;
  logic         vld_empty;
  logic [VAW:0] vld_usedw;
  logic         vld_ovf;
  logic         vld_rd;
  logic         head_last;

  port_rx_buffer_fifo #(.WIDTH(134), .DEPTH(PKT_DEPTH)) u_pkt_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_if.pkt_wrreq),
    .din   (in_if.pkt),
    .rd    (pkt_rd),
    .q     (pkt_head),
    .empty (pkt_empty),
    .usedw (pkt_usedw),
    .ovf   (pkt_ovf)
  );

  port_rx_buffer_fifo #(.WIDTH(1), .DEPTH(VLD_DEPTH)) u_vld_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (in_if.valid_wrreq),
    .din   (in_if.valid),
    .rd    (vld_rd),
    .q     (flag_head),
    .empty (vld_empty),
    .usedw (vld_usedw),
    .ovf   (vld_ovf)
  );

  assign head_last = (pkt_head[133:132] == 2'b10);
  // Downstream almost-full is honoured only when choosing to start a packet.
  assign vld_rd    = (state == IDLE) & ~vld_empty & ~out_if.pkt_almostfull;
  // SEND and DISCARD both consume one word per cycle whenever one is present.
  assign pkt_rd    = (state != IDLE) & ~pkt_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      out_if.pkt_wrreq     <= 1'b0;
      out_if.pkt           <= '0;
      out_if.valid_wrreq   <= 1'b0;
      out_if.valid         <= 1'b0;
      in_if.pkt_almostfull <= 1'b0;
      pkt_forward_add      <= 1'b0;
      pkt_drop_add         <= 1'b0;
      overflow_add         <= 1'b0;
    end else begin
      out_if.pkt_wrreq     <= 1'b0;
      out_if.valid_wrreq   <= 1'b0;
      out_if.valid         <= 1'b0;
      pkt_forward_add      <= 1'b0;
      pkt_drop_add         <= 1'b0;
      // Either or both FIFOs rejecting a write in the same cycle gives one pulse.
      overflow_add         <= pkt_ovf | vld_ovf;
      in_if.pkt_almostfull <= (pkt_usedw >= PKT_AF_LVL) | (vld_usedw >= VLD_AF_LVL);

      case (state)
        IDLE: begin
          if (vld_rd) state <= flag_head ? SEND : DISCARD;
        end
        SEND: begin
          if (pkt_rd) begin
            out_if.pkt       <= pkt_head;
            out_if.pkt_wrreq <= 1'b1;
            if (head_last) begin
              out_if.valid_wrreq <= 1'b1;
              out_if.valid       <= 1'b1;
              pkt_forward_add    <= 1'b1;
              state              <= IDLE;
            end
          end
        end
        DISCARD: begin
          if (pkt_rd && head_last) begin
            pkt_drop_add <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_port_rx_buffer.sv
`timescale 1ns/1ps
module tb_port_rx_buffer;
  logic clk = 1'b0;
  logic reset;
  logic pkt_forward_add, pkt_drop_add, overflow_add;

  port_rx_buffer_if in_bus();
  port_rx_buffer_if out_bus();

  port_rx_buffer #(.PKT_DEPTH(256), .VLD_DEPTH(64), .AF_MARGIN(24)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_if           (in_bus),
    .out_if          (out_bus),
    .pkt_forward_add (pkt_forward_add),
    .pkt_drop_add    (pkt_drop_add),
    .overflow_add    (overflow_add)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [133:0] got_q[$];
  logic [133:0] exp_q[$];
  int fwd_cnt = 0, drop_cnt = 0, ovf_cnt = 0;
  int exp_fwd = 0, exp_drop = 0;
  int pkt_id = 1;
  int last_nwords = 0;
  bit rnd_af = 1'b0;

  task automatic chk(input string name, input logic [133:0] act, input logic [133:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [133:0] mkw(input int i, input int n, input logic [3:0] inv, input int id);
    logic [1:0] m;
    logic [3:0] b;
    m = (i == 0) ? 2'b01 : ((i == n - 1) ? 2'b10 : 2'b11);
    b = (i == n - 1) ? inv : 4'h0;
    return {m, b, 32'(id), 32'(i), 32'(id * 7 + i), 32'hA5A5_5A5A};
  endfunction

  // Output monitor: collects forwarded words and statistics pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (out_bus.pkt_wrreq) got_q.push_back(out_bus.pkt);
      if (pkt_forward_add) fwd_cnt++;
      if (pkt_drop_add) drop_cnt++;
      if (overflow_add) ovf_cnt++;
      if (out_bus.valid_wrreq || (out_bus.pkt_wrreq && out_bus.pkt[133:132] == 2'b10))
        chk("last_word_strobes",
            {out_bus.valid_wrreq, out_bus.valid, out_bus.pkt_wrreq, out_bus.pkt[133:132], pkt_forward_add},
            6'b111101);
    end
  end

  // mode 0: flag with last word, 1: flag the cycle after, 2: no flag.
  task automatic send_pkt(input int n, input bit keep, input logic [3:0] inv, input int mode);
    logic [133:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rnd_af) out_bus.pkt_almostfull = ($urandom_range(0, 3) == 0);
      w = mkw(i, n, inv, pkt_id);
      in_bus.pkt_wrreq   = 1'b1;
      in_bus.pkt         = w;
      in_bus.valid_wrreq = 1'b0;
      if (keep) exp_q.push_back(w);
      if (mode == 0 && i == n - 1) begin
        in_bus.valid_wrreq = 1'b1;
        in_bus.valid       = keep;
      end
    end
    @(negedge clk);
    in_bus.pkt_wrreq   = 1'b0;
    in_bus.valid_wrreq = 1'b0;
    if (mode == 1) begin
      in_bus.valid_wrreq = 1'b1;
      in_bus.valid       = keep;
      @(negedge clk);
      in_bus.valid_wrreq = 1'b0;
    end
    pkt_id++;
    if (mode != 2) begin
      if (keep) exp_fwd++;
      else exp_drop++;
    end
  endtask

  task automatic wait_drain(input string name);
    int k;
    int n;
    k = 0;
    while ((got_q.size() < exp_q.size() || fwd_cnt < exp_fwd || drop_cnt < exp_drop) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_timeout"}, k < 2000, 1'b1);
    repeat (4) @(negedge clk);
    last_nwords = got_q.size();
    chk({name, "_nwords"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({name, "_word"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
    chk({name, "_fwd"}, fwd_cnt, exp_fwd);
    chk({name, "_drop"}, drop_cnt, exp_drop);
  endtask

  typedef struct {
    int         n;
    bit         keep;
    logic [3:0] inv;
    int         exp_words;
    int         exp_fwd_inc;
    int         exp_drop_inc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int k, f0, d0, o0;
    logic [133:0] w;

    vecs[0] = '{4, 1'b1, 4'd3, 4, 1, 0};
    vecs[1] = '{6, 1'b0, 4'd0, 0, 0, 1};
    vecs[2] = '{2, 1'b1, 4'd5, 2, 1, 0};
    vecs[3] = '{3, 1'b0, 4'd1, 0, 0, 1};
    vecs[4] = '{12, 1'b1, 4'd15, 12, 1, 0};

    reset = 1'b0;
    in_bus.pkt_wrreq = 1'b0;
    in_bus.pkt = '0;
    in_bus.valid_wrreq = 1'b0;
    in_bus.valid = 1'b0;
    out_bus.pkt_almostfull = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {out_bus.pkt_wrreq, out_bus.valid_wrreq, out_bus.valid, in_bus.pkt_almostfull,
         pkt_forward_add, pkt_drop_add, overflow_add, |out_bus.pkt}, 8'h00);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Single good packet: first output word exactly 3 cycles after the flag write.
    send_pkt(4, 1'b1, 4'd3, 2);
    in_bus.valid_wrreq = 1'b1;
    in_bus.valid = 1'b1;
    exp_fwd++;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) in_bus.valid_wrreq = 1'b0;
      if (out_bus.pkt_wrreq && k == 0) k = c;
    end
    chk("first_word_latency", k, 3);
    wait_drain("single");

    // Table-driven packets.
    for (int i = 0; i < 5; i++) begin
      f0 = fwd_cnt;
      d0 = drop_cnt;
      send_pkt(vecs[i].n, vecs[i].keep, vecs[i].inv, i % 2);
      wait_drain("vec");
      chk("vec_out_words", last_nwords, vecs[i].exp_words);
      chk("vec_fwd_inc", fwd_cnt - f0, vecs[i].exp_fwd_inc);
      chk("vec_drop_inc", drop_cnt - d0, vecs[i].exp_drop_inc);
    end

    // Downstream backpressure.
    out_bus.pkt_almostfull = 1'b1;
    send_pkt(3, 1'b1, 4'd0, 0);
    send_pkt(5, 1'b1, 4'd2, 1);
    send_pkt(4, 1'b1, 4'd7, 0);
    repeat (20) @(negedge clk);
    chk("bp_hold_no_output", got_q.size(), 0);
    out_bus.pkt_almostfull = 1'b0;
    k = 0;
    while (got_q.size() == 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    out_bus.pkt_almostfull = 1'b1;
    repeat (30) @(negedge clk);
    chk("bp_midpkt_complete", got_q.size(), 3);
    out_bus.pkt_almostfull = 1'b0;
    wait_drain("bp");

    // Almost-full threshold then overflow: 256 words (one packet) plus a stray 257th.
    o0 = ovf_cnt;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i == 232) chk("af_before_232", in_bus.pkt_almostfull, 1'b0);
      if (i == 233) chk("af_at_232", in_bus.pkt_almostfull, 1'b1);
      w = (i < 256) ? mkw(i, 256, 4'd0, pkt_id) : mkw(0, 2, 4'd0, pkt_id + 1);
      in_bus.pkt_wrreq = 1'b1;
      in_bus.pkt = w;
      if (i < 256) exp_q.push_back(w);
    end
    @(negedge clk);
    in_bus.pkt_wrreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("overflow_pulses", ovf_cnt - o0, 1);
    chk("af_while_full", in_bus.pkt_almostfull, 1'b1);
    pkt_id += 2;
    in_bus.valid_wrreq = 1'b1;
    in_bus.valid = 1'b1;
    exp_fwd++;
    @(negedge clk);
    in_bus.valid_wrreq = 1'b0;
    wait_drain("ovf");
    chk("af_clear", in_bus.pkt_almostfull, 1'b0);
    send_pkt(2, 1'b1, 4'd4, 0);
    wait_drain("post_ovf");

    // Reset in the middle of a forwarded packet.
    f0 = fwd_cnt;
    send_pkt(10, 1'b1, 4'd0, 1);
    k = 0;
    while (got_q.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    reset = 1'b0;
    #1;
    chk("rst_strobes_low",
        {out_bus.pkt_wrreq, out_bus.valid_wrreq, out_bus.valid, in_bus.pkt_almostfull,
         pkt_forward_add, pkt_drop_add, overflow_add}, 7'h00);
    repeat (2) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    exp_fwd--;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_fwd_pulse", fwd_cnt - f0, 0);
    chk("rst_no_output", got_q.size(), 0);
    send_pkt(3, 1'b1, 4'd9, 0);
    wait_drain("post_reset");

    // Randomized packets against the queue model.
    rnd_af = 1'b1;
    for (int p = 0; p < 40; p++) begin
      k = 0;
      while (in_bus.pkt_almostfull && k < 500) begin
        @(negedge clk);
        out_bus.pkt_almostfull = ($urandom_range(0, 3) == 0);
        k++;
      end
      chk("rand_af_wait", k < 500, 1'b1);
      send_pkt($urandom_range(2, 12), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
               $urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        out_bus.pkt_almostfull = ($urandom_range(0, 3) == 0);
      end
    end
    rnd_af = 1'b0;
    out_bus.pkt_almostfull = 1'b0;
    wait_drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
